// File: rtl/niossoc_pio_pkg.sv
// Shared constants for the Nios SoC input PIO: register offsets, edge-type
// encodings and a counter-width helper.
package niossoc_pio_pkg;

    localparam logic [1:0] PIO_DATA    = 2'd0;
    localparam logic [1:0] PIO_RSVD    = 2'd1;
    localparam logic [1:0] PIO_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Width of a counter that must hold the value n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/niossoc_pio_debounce.sv
// One input bit: SYNC_STAGES-deep synchronizer followed by an optional
// consecutive-stable-clocks debounce filter.
module niossoc_pio_debounce
    import niossoc_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic armed,
    input  logic din,
    output logic dout
);

    localparam int CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam int LAST_I = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign dout   = r_stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Before arming (or in bypass) the filter tracks sync directly so idle-high
    // inputs settle without being treated as a change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!armed || DEBOUNCE_CYCLES == 0 || w_sync == r_stable) begin
            r_cnt    <= '0;
            r_stable <= w_sync;
        end else if (r_cnt == LAST) begin
            r_cnt    <= '0;
            r_stable <= w_sync;
        end else begin
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/niossoc_pio_in.sv
// Avalon-MM input PIO: synchronised/debounced inputs, per-bit edge capture
// with W1C clear, interrupt mask and a level irq. Zero-wait-state reads.
module niossoc_pio_in
    import niossoc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int AW      = cnt_width(ARM_CNT);

    logic [AW-1:0]    r_arm_cnt;
    logic             r_armed;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic             w_wr;
    logic             w_unused_wdata;

    // Arm one clock after the synchronizers have flushed, so the settling
    // transition of the first sampled value never registers as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            if (r_arm_cnt == AW'(ARM_CNT)) begin
                r_armed <= 1'b1;
            end else begin
                r_arm_cnt <= r_arm_cnt + AW'(1);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        niossoc_pio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .armed   (r_armed),
            .din     (in_port[i]),
            .dout    (w_stable[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
        assign w_edge_raw = w_stable & ~r_stable_d;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign w_edge_raw = ~w_stable & r_stable_d;
    end else begin : g_any
        assign w_edge_raw = w_stable ^ r_stable_d;
    end

    assign w_edge = w_edge_raw & {WIDTH{r_armed}};
    assign w_wr   = chipselect & ~write_n;
    assign w_clr  = (w_wr && address == PIO_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // A new edge overrides a clear landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
            r_irqmask <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
            if (w_wr && address == PIO_IRQMASK) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA:    readdata[WIDTH-1:0] = w_stable;
            PIO_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
            PIO_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
            default:     readdata = '0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

    assign w_unused_wdata = &{1'b0, writedata};

endmodule

// File: tb/tb_niossoc_pio_in.sv
// Scoreboard bench for niossoc_pio_in: three instances (rising/no debounce,
// rising/debounce 4, falling) driven by directed vectors.
module tb_niossoc_pio_in;
    import niossoc_pio_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic [2:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in0, in1, in2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        irq0, irq1, irq2;
    logic        irq_probe;
    logic        end_check;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [31:0] act;

    niossoc_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rdata0), .irq(irq0)
    );

    niossoc_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rdata1), .irq(irq1)
    );

    niossoc_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rdata2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input int d, input bit is_irq);
        case (d)
            0:       return is_irq ? {31'b0, irq0} : rdata0;
            1:       return is_irq ? {31'b0, irq1} : rdata1;
            default: return is_irq ? {31'b0, irq2} : rdata2;
        endcase
    endfunction

    // Monitor: pops one expectation whenever a read or irq probe is presented.
    always @(negedge clk) begin
        if ((|cs && write_n) || irq_probe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: no expectation queued at %0t", $time);
            end else begin
                e = sb.pop_front();
                act = pick(e.dut, e.is_irq);
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: dut%0d got 0x%08h expected 0x%08h at %0t",
                             e.name, e.dut, act, e.exp, $time);
                end
            end
        end
        if (end_check) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] x, input string nm);
        address = a;
        write_n = 1'b1;
        cs      = 3'b000;
        cs[d]   = 1'b1;
        sb.push_back('{dut: d, is_irq: 1'b0, exp: x, name: nm});
        tick();
        cs = 3'b000;
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
        address   = a;
        writedata = v;
        write_n   = 1'b0;
        cs        = 3'b000;
        cs[d]     = 1'b1;
        tick();
        cs      = 3'b000;
        write_n = 1'b1;
    endtask

    task automatic chk_irq(input int d, input logic x, input string nm);
        irq_probe = 1'b1;
        sb.push_back('{dut: d, is_irq: 1'b1, exp: {31'b0, x}, name: nm});
        tick();
        irq_probe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs        = 3'b000;
        write_n   = 1'b1;
        writedata = '0;
        in0       = 4'hF;
        in1       = 4'h0;
        in2       = 4'hF;
        irq_probe = 1'b0;
        end_check = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Startup with inputs idling high: no spurious capture.
        for (int i = 0; i < 4; i++) rd(0, PIO_EDGECAP, 32'h0, "startup_edgecap");
        rd(0, PIO_DATA, 32'hF, "startup_data");
        chk_irq(0, 1'b0, "startup_irq");
        rd(0, PIO_EDGECAP, 32'h0, "armed_no_spurious");
        rd(0, PIO_EDGECAP, 32'h0, "armed_no_spurious2");
        rd(0, PIO_RSVD, 32'h0, "reserved_reads_0");

        // Falling transition on a rising-edge instance is ignored.
        in0 = 4'hD;
        repeat (5) tick();
        rd(0, PIO_EDGECAP, 32'h0, "rise_ignores_fall");
        rd(0, PIO_DATA, 32'hD, "data_d");

        // Bit1 rising: exact latency of DATA and capture.
        in0 = 4'hF;
        rd(0, PIO_EDGECAP, 32'h0, "lat_cap_before");
        rd(0, PIO_DATA, 32'hD, "lat_data_n1");
        rd(0, PIO_DATA, 32'hD, "lat_data_n2");
        rd(0, PIO_DATA, 32'hF, "lat_data_n3");
        rd(0, PIO_EDGECAP, 32'h2, "lat_cap_n4");
        chk_irq(0, 1'b0, "irq_masked");
        wr(0, PIO_IRQMASK, 32'h2);
        chk_irq(0, 1'b1, "irq_after_mask");
        rd(0, PIO_IRQMASK, 32'h2, "irqmask_readback");
        wr(0, PIO_DATA, 32'h0);
        rd(0, PIO_DATA, 32'hF, "data_write_ignored");

        // Build capture 0x6, then W1C in two steps.
        in0 = 4'hB;
        repeat (5) tick();
        in0 = 4'hF;
        repeat (5) tick();
        rd(0, PIO_EDGECAP, 32'h6, "cap_0x6");
        wr(0, PIO_EDGECAP, 32'h4);
        rd(0, PIO_EDGECAP, 32'h2, "w1c_bit2");
        chk_irq(0, 1'b1, "irq_still_set");
        wr(0, PIO_EDGECAP, 32'h2);
        rd(0, PIO_EDGECAP, 32'h0, "w1c_bit1");
        chk_irq(0, 1'b0, "irq_cleared");

        // W1C of bit0 on the very edge bit0 is captured: set wins.
        in0 = 4'hE;
        repeat (5) tick();
        in0 = 4'hF;
        repeat (3) tick();
        wr(0, PIO_EDGECAP, 32'h1);
        rd(0, PIO_EDGECAP, 32'h1, "set_beats_clear");
        chk_irq(0, 1'b0, "unmasked_bit_no_irq");
        wr(0, PIO_EDGECAP, 32'h1);
        rd(0, PIO_EDGECAP, 32'h0, "w1c_bit0");

        // Debounce 4: a 3-clock glitch is rejected.
        in1 = 4'h1;
        repeat (3) tick();
        in1 = 4'h0;
        repeat (8) tick();
        rd(1, PIO_DATA, 32'h0, "deb_glitch_data");
        rd(1, PIO_EDGECAP, 32'h0, "deb_glitch_cap");

        // Debounce 4: a 4-clock pulse is accepted.
        in1 = 4'h1;
        repeat (4) tick();
        in1 = 4'h0;
        tick();
        rd(1, PIO_DATA, 32'h0, "deb_data_before");
        rd(1, PIO_DATA, 32'h1, "deb_data_accepted");
        rd(1, PIO_EDGECAP, 32'h1, "deb_cap");
        repeat (8) tick();
        rd(1, PIO_DATA, 32'h0, "deb_data_released");

        // Falling-edge instance.
        rd(2, PIO_EDGECAP, 32'h0, "fall_startup_cap");
        in2 = 4'h7;
        repeat (5) tick();
        rd(2, PIO_EDGECAP, 32'h8, "fall_cap");
        wr(2, PIO_EDGECAP, 32'h8);
        rd(2, PIO_EDGECAP, 32'h0, "fall_w1c");
        in2 = 4'hF;
        repeat (5) tick();
        rd(2, PIO_EDGECAP, 32'h0, "fall_ignores_rise");
        in2 = 4'h7;
        repeat (5) tick();
        rd(2, PIO_EDGECAP, 32'h8, "fall_cap_again");
        wr(2, PIO_IRQMASK, 32'h8);
        chk_irq(2, 1'b1, "fall_irq");

        // Asynchronous reset between edges clears state at once.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        rd(2, PIO_EDGECAP, 32'h0, "rst_edgecap");
        rd(2, PIO_IRQMASK, 32'h0, "rst_irqmask");
        chk_irq(2, 1'b0, "rst_irq");
        rd(2, PIO_DATA, 32'h0, "rst_data");
        reset_n = 1'b1;

        // Re-arming after reset again suppresses the idle-high transition.
        for (int i = 0; i < 8; i++) rd(0, PIO_EDGECAP, 32'h0, "rearm_edgecap");
        rd(0, PIO_DATA, 32'hF, "rearm_data");
        rd(2, PIO_DATA, 32'h7, "rearm_data_fall");
        rd(2, PIO_EDGECAP, 32'h0, "rearm_fall_cap");

        end_check = 1'b1;
        tick();
        end_check = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
